countdown_timer: RTL

Parametrised multi-digit countdown timer built as a chain of per-digit down-counters with borrow propagation, per-digit modulus, and a run/pause/expire state machine. Each digit counts from its own `max_count` down to 0; for example, an MM:SS display uses moduli 5/9/5/9. The block sits between the step-pulse source (debounced button or prescaled tick) and the seven-segment display driver. It replaces hand-chained single-digit timers.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_digit.sv | 53 +++++
 rtl/countdown_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the multi-digit countdown timer.
package timer_pkg;

  localparam int DEFAULT_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

  typedef logic [DEFAULT_DIGIT_W-1:0] digit_t;

endpackage

// File: rtl/timer_digit.sv
// One down-counting digit with its own modulus; borrows ripple combinationally
// to the next digit so the whole chain settles within the tick cycle.
module timer_digit
  import timer_pkg::*;
#(
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_value,
  input  logic [DIGIT_W-1:0] max_count,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] count,
  output logic               borrow_out,
  output logic               wrap
);

  localparam logic [DIGIT_W-1:0] ZERO_C = {DIGIT_W{1'b0}};
  localparam logic [DIGIT_W-1:0] ONE_C  = {{(DIGIT_W-1){1'b0}}, 1'b1};

  logic [DIGIT_W-1:0] count_r;
  logic               wrap_r;
  logic               at_zero_s;

  assign at_zero_s  = (count_r == ZERO_C);
  assign borrow_out = borrow_in & at_zero_s;
  assign count      = count_r;
  assign wrap       = wrap_r;

  // Digit value and one-cycle wrap flag; load beats any incoming borrow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_r <= ZERO_C;
      wrap_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_value;
      wrap_r  <= 1'b0;
    end else if (borrow_in) begin
      if (at_zero_s) begin
        count_r <= max_count;
        wrap_r  <= 1'b1;
      end else begin
        count_r <= count_r - ONE_C;
        wrap_r  <= 1'b0;
      end
    end else begin
      count_r <= count_r;
      wrap_r  <= 1'b0;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Multi-digit countdown timer: step edge detector, run/pause/expire FSM and clamp.
// Optional COUNTDOWN_TIMER_AUTO_RELOAD_EN reloads the last set value on expiry.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = DEFAULT_DIGIT_W
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          step,
  input  logic                          set,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] set_value,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] max_count,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count_out,
  output logic [NUM_DIGITS-1:0]         wrap,
  output logic                          done,
  output logic                          expired,
  output logic                          running
);

  localparam int TOTAL_W = NUM_DIGITS * DIGIT_W;
  localparam logic [TOTAL_W-1:0] ZERO_C = {TOTAL_W{1'b0}};
  localparam logic [TOTAL_W-1:0] ONE_C  = {{(TOTAL_W-1){1'b0}}, 1'b1};

  timer_state_t        state_r, state_s;
  logic                step_q_r;
  logic                expired_r;
  logic                tick_s;
  logic                terminal_s;
  logic                reload_hit_s;
  logic                load_s;
  logic [TOTAL_W-1:0]  clamp_s;
  logic [TOTAL_W-1:0]  reload_value_s;
  logic [TOTAL_W-1:0]  load_value_s;
  logic [TOTAL_W-1:0]  count_s;
  logic [NUM_DIGITS:0] borrow_s;

  // set suppresses the tick so a simultaneous set always wins
  assign tick_s     = step & ~step_q_r & enable & (state_r == RUN) & ~set;
  assign terminal_s = (count_s == ONE_C);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [TOTAL_W-1:0] reload_r;

  // Reload register remembers the last clamped set value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      reload_r <= ZERO_C;
    end else if (set) begin
      reload_r <= clamp_s;
    end else begin
      reload_r <= reload_r;
    end
  end

  assign reload_hit_s   = tick_s & terminal_s & (reload_r != ZERO_C);
  assign reload_value_s = reload_r;
`else
  assign reload_hit_s   = 1'b0;
  assign reload_value_s = ZERO_C;
`endif

  assign load_s       = set | reload_hit_s;
  assign load_value_s = set ? clamp_s : reload_value_s;
  assign borrow_s[0]  = tick_s;

  genvar d;
  generate
    for (d = 0; d < NUM_DIGITS; d++) begin : g_digit
      assign clamp_s[d*DIGIT_W +: DIGIT_W] =
        (set_value[d*DIGIT_W +: DIGIT_W] > max_count[d*DIGIT_W +: DIGIT_W]) ?
        max_count[d*DIGIT_W +: DIGIT_W] : set_value[d*DIGIT_W +: DIGIT_W];

      timer_digit #(.DIGIT_W(DIGIT_W)) u_digit (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_s),
        .load_value (load_value_s[d*DIGIT_W +: DIGIT_W]),
        .max_count  (max_count[d*DIGIT_W +: DIGIT_W]),
        .borrow_in  (borrow_s[d]),
        .count      (count_s[d*DIGIT_W +: DIGIT_W]),
        .borrow_out (borrow_s[d+1]),
        .wrap       (wrap[d])
      );
    end
  endgenerate

  // State, step history and expiry pulse; step_q resets high to swallow a held step.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      step_q_r  <= 1'b1;
      expired_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      step_q_r  <= step;
      expired_r <= tick_s & terminal_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    if (set) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable && (count_s != ZERO_C)) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (!enable) begin
            state_s = IDLE;
          end else if (tick_s && terminal_s && !reload_hit_s) begin
            state_s = EXPIRED;
          end else begin
            state_s = RUN;
          end
        end
        EXPIRED: state_s = EXPIRED;
        default: state_s = IDLE;
      endcase
    end
  end

  assign count_out = count_s;
  assign done      = (count_s == ZERO_C);
  assign expired   = expired_r;
  assign running   = (state_r == RUN);

endmodule
